// File: rtl/alu_exec_unit.sv
// Integer execution unit: single-cycle base ALU operations plus iterative
// multiply (shift-add) and restoring divide, behind a valid/ready handshake.
module alu_exec_unit #(
   parameter int XLEN = 32,
   parameter int M_EN = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [1:0]      ALUOp_i,
   input  logic [2:0]      funct3_i,
   input  logic [6:0]      funct7_i,
   input  logic [XLEN-1:0] src1_i,
   input  logic [XLEN-1:0] src2_i,
   output logic [XLEN-1:0] result_o,
   output logic            valid_o,
   input  logic            ready_i,
   output logic            illegal_o
);

   localparam int SHW = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Decode and base ALU signals (driven straight from the request inputs)
   logic [SHW-1:0]  shamt;
   logic            use_sub, use_sra, is_m, is_ill;
   logic [XLEN-1:0] base_res;
   logic            a_neg_c, b_neg_c;
   logic [XLEN-1:0] mag_a, mag_b;

   // Multiply/divide working state
   logic [SHW-1:0]  count;
   logic [2:0]      m_f3;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] work_hi, work_lo, opnd;

   // One iteration of the multiply/divide datapath and the final sign fix-up
   logic [XLEN:0]     mul_sum, div_shift;
   logic              div_ge;
   logic [XLEN-1:0]   div_sub, step_hi, step_lo;
   logic [2*XLEN-1:0] prod, prod_s;
   logic [XLEN-1:0]   quot_s, rem_s, m_res;
   logic              last_step;

   assign shamt     = src2_i[SHW-1:0];
   assign ready_o   = (state_q == IDLE);
   assign valid_o   = (state_q == DONE);
   assign last_step = (state_q == BUSY) && (count == SHW'(XLEN - 1));

   // Operand signedness: div/rem signed on both, mulhsu signed only on A,
   // mulhu/divu/remu unsigned; mul uses signed magnitudes (low half is identical).
   assign a_neg_c = src1_i[XLEN-1] & (funct3_i[2] ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11));
   assign b_neg_c = src2_i[XLEN-1] & (funct3_i[2] ? ~funct3_i[0] : ~funct3_i[1]);
   assign mag_a   = a_neg_c ? -src1_i : src1_i;
   assign mag_b   = b_neg_c ? -src2_i : src2_i;

   // Classify the request: base op (with add/sub and srl/sra selection), M op, or illegal
   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      use_sub = 1'b0;
      use_sra = 1'b0;
      is_m    = 1'b0;
      is_ill  = 1'b0;
      case (ALUOp_i)
         2'b10: begin
            if (funct7_i == 7'b0000000) begin
               use_sub = 1'b0;
            end else if (funct7_i == 7'b0100000) begin
               use_sub = 1'b1;
               use_sra = 1'b1;
               if (funct3_i != 3'b000 && funct3_i != 3'b101) begin
                  is_ill = 1'b1;
               end
            end else if (funct7_i == 7'b0000001 && M_EN != 0) begin
               is_m = 1'b1;
            end else begin
               is_ill = 1'b1;
            end
         end
         2'b11: begin
            // I-type: funct7 is part of the immediate except bit 5 for right shifts
            use_sra = funct7_i[5];
         end
         default: is_ill = 1'b1;
      endcase
   end

   // Single-cycle base ALU result
   always_comb begin
      base_res = '0;
      case (funct3_i)
         3'b000: base_res = use_sub ? (src1_i - src2_i) : (src1_i + src2_i);
         3'b001: base_res = src1_i << shamt;
         3'b010: base_res = {{(XLEN-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
         3'b011: base_res = {{(XLEN-1){1'b0}}, (src1_i < src2_i)};
         3'b100: base_res = src1_i ^ src2_i;
         3'b101: base_res = use_sra ? $unsigned($signed(src1_i) >>> shamt) : (src1_i >> shamt);
         3'b110: base_res = src1_i | src2_i;
         default: base_res = src1_i & src2_i;
      endcase
   end

   // Next iteration of shift-add multiply or restoring divide, plus sign fix-up
   always_comb begin
      mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
      div_shift = {work_hi, work_lo[XLEN-1]};
      div_ge    = (div_shift >= {1'b0, opnd});
      div_sub   = div_shift[XLEN-1:0] - opnd;
      if (m_f3[2]) begin
         step_hi = div_ge ? div_sub : div_shift[XLEN-1:0];
         step_lo = {work_lo[XLEN-2:0], div_ge};
      end else begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], work_lo[XLEN-1:1]};
      end
      prod   = {step_hi, step_lo};
      prod_s = (a_neg ^ b_neg) ? -prod : prod;
      // A zero divisor leaves an all-ones magnitude quotient; it must not be negated.
      quot_s = (opnd == '0) ? '1 : ((a_neg ^ b_neg) ? -step_lo : step_lo);
      rem_s  = a_neg ? -step_hi : step_hi;
      if (!m_f3[2]) begin
         m_res = (m_f3[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
      end else begin
         m_res = m_f3[1] ? rem_s : quot_s;
      end
   end

   // Next-state logic for the IDLE/BUSY/DONE handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (valid_i) state_d = is_m ? BUSY : DONE;
         BUSY:    if (last_step) state_d = DONE;
         DONE:    if (ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Request capture, multiply/divide iteration and result registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         result_o  <= '0;
         illegal_o <= 1'b0;
         count     <= '0;
         m_f3      <= '0;
         a_neg     <= 1'b0;
         b_neg     <= 1'b0;
         work_hi   <= '0;
         work_lo   <= '0;
         opnd      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (valid_i) begin
                  count <= '0;
                  m_f3  <= funct3_i;
                  a_neg <= a_neg_c;
                  b_neg <= b_neg_c;
                  if (is_m) begin
                     work_hi <= '0;
                     work_lo <= funct3_i[2] ? mag_a : mag_b;
                     opnd    <= funct3_i[2] ? mag_b : mag_a;
                  end else begin
                     result_o  <= is_ill ? '0 : base_res;
                     illegal_o <= is_ill;
                  end
               end
            end
            BUSY: begin
               count   <= count + SHW'(1);
               work_hi <= step_hi;
               work_lo <= step_lo;
               if (last_step) begin
                  result_o  <= m_res;
                  illegal_o <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, random
// operations against an arithmetic reference model, and handshake/reset sequences.
module tb_alu_exec_unit;

   localparam int XL = 32;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          valid_i, ready_i;
   logic [1:0]    ALUOp_i;
   logic [2:0]    funct3_i;
   logic [6:0]    funct7_i;
   logic [XL-1:0] src1_i, src2_i;
   logic          ready_o, valid_o, illegal_o;
   logic [XL-1:0] result_o;

   logic          nm_valid_i, nm_ready_i;
   logic          nm_ready_o, nm_valid_o, nm_illegal_o;
   logic [XL-1:0] nm_result_o;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic          ill;
      logic [XL-1:0] res;
      logic [7:0]    lat;
   } exp_t;

   typedef struct {
      logic [1:0]    op;
      logic [2:0]    f3;
      logic [6:0]    f7;
      logic [XL-1:0] a;
      logic [XL-1:0] b;
      logic [XL-1:0] res;
      logic          ill;
      int            lat;
   } vec_t;

   always #5 clk_i = ~clk_i;

   alu_exec_unit #(.XLEN(XL), .M_EN(1)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .ALUOp_i(ALUOp_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
      .src1_i(src1_i), .src2_i(src2_i), .result_o(result_o),
      .valid_o(valid_o), .ready_i(ready_i), .illegal_o(illegal_o)
   );

   alu_exec_unit #(.XLEN(XL), .M_EN(0)) dut_nm (
      .clk_i(clk_i), .rst_i(rst_i), .valid_i(nm_valid_i), .ready_o(nm_ready_o),
      .ALUOp_i(ALUOp_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
      .src1_i(src1_i), .src2_i(src2_i), .result_o(nm_result_o),
      .valid_o(nm_valid_o), .ready_i(nm_ready_i), .illegal_o(nm_illegal_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: plain 64-bit arithmetic on the operation's mnemonic
   function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [XL-1:0] a, input logic [XL-1:0] b, input bit m_en);
      exp_t        e;
      longint      sa, sb, ub, p;
      logic [63:0] up;
      logic [4:0]  sh;
      bit          base, arith;
      bit          ovf;
      e.ill = 1'b0; e.res = '0; e.lat = 8'd1;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'b0, b});
      sh = b[4:0];
      p = 0; up = '0;
      base = 0; arith = 0;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (op == 2'b10 && f7 == 7'h00) begin
         base = 1;
      end else if (op == 2'b10 && f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) begin
         base = 1; arith = 1;
      end else if (op == 2'b10 && f7 == 7'h01 && m_en) begin
         e.lat = 8'd33;
         case (f3)
            3'b000: begin p = sa * sb; e.res = p[31:0]; end
            3'b001: begin p = sa * sb; e.res = p[63:32]; end
            3'b010: begin p = sa * ub; e.res = p[63:32]; end
            3'b011: begin up = {32'b0, a} * {32'b0, b}; e.res = up[63:32]; end
            3'b100: begin
               if (b == 0) e.res = 32'hFFFF_FFFF;
               else if (ovf) e.res = a;
               else begin p = sa / sb; e.res = p[31:0]; end
            end
            3'b101: e.res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
               if (b == 0) e.res = a;
               else if (ovf) e.res = '0;
               else begin p = sa % sb; e.res = p[31:0]; end
            end
            default: e.res = (b == 0) ? a : a % b;
         endcase
      end else if (op == 2'b11) begin
         base = 1; arith = (f3 == 3'b101) && f7[5];
      end else begin
         e.ill = 1'b1;
      end
      if (base) begin
         case (f3)
            3'b000: e.res = arith ? a - b : a + b;
            3'b001: e.res = a << sh;
            3'b010: e.res = {31'b0, sa < sb};
            3'b011: e.res = {31'b0, a < b};
            3'b100: e.res = a ^ b;
            3'b101: begin p = sa >>> sh; e.res = arith ? p[31:0] : a >> sh; end
            3'b110: e.res = a | b;
            default: e.res = a & b;
         endcase
      end
      return e;
   endfunction

   function automatic logic [XL-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return 32'($urandom);
      endcase
   endfunction

   // Issue one request at a falling edge with the unit idle and ready_i=1;
   // returns the result and the number of cycles until valid_o was seen.
   task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [XL-1:0] a, input logic [XL-1:0] b,
                         output logic [XL-1:0] res, output logic ill, output int lat);
      ALUOp_i = op; funct3_i = f3; funct7_i = f7; src1_i = a; src2_i = b;
      valid_i = 1'b1;
      @(posedge clk_i);
      lat = 0;
      do begin
         @(negedge clk_i);
         lat++;
         valid_i  = 1'b0;
         ALUOp_i  = 2'($urandom);
         funct3_i = 3'($urandom);
         funct7_i = 7'($urandom);
         src1_i   = 32'($urandom);
         src2_i   = 32'($urandom);
      end while (!valid_o && lat < 100);
      if (!valid_o) check("latency_bound", 64'(valid_o), 64'd1);
      res = result_o;
      ill = illegal_o;
      @(negedge clk_i);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t          vecs[$];
      exp_t          e;
      logic [XL-1:0] res, held;
      logic          ill;
      logic [1:0]    op;
      logic [6:0]    f7;
      int            lat, seen;

      vecs.push_back('{2'b10, 3'b000, 7'h00, 32'd5,          32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 1});
      vecs.push_back('{2'b11, 3'b101, 7'h20, 32'h8000_0000, 32'h0000_0404, 32'hF800_0000, 1'b0, 1});
      vecs.push_back('{2'b10, 3'b001, 7'h01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33});
      vecs.push_back('{2'b10, 3'b100, 7'h01, 32'd7,          32'd0,         32'hFFFF_FFFF, 1'b0, 33});
      vecs.push_back('{2'b10, 3'b110, 7'h01, 32'd7,          32'd0,         32'd7,         1'b0, 33});
      vecs.push_back('{2'b10, 3'b100, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33});
      vecs.push_back('{2'b10, 3'b110, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 33});
      vecs.push_back('{2'b10, 3'b101, 7'h01, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 1'b0, 33});
      vecs.push_back('{2'b10, 3'b111, 7'h01, 32'h1234_5678, 32'd0,         32'h1234_5678, 1'b0, 33});
      vecs.push_back('{2'b00, 3'b000, 7'h00, 32'd5,          32'd7,         32'd0,         1'b1, 1});
      vecs.push_back('{2'b01, 3'b000, 7'h00, 32'd5,          32'd7,         32'd0,         1'b1, 1});
      vecs.push_back('{2'b10, 3'b001, 7'h20, 32'd5,          32'd7,         32'd0,         1'b1, 1});
      vecs.push_back('{2'b10, 3'b000, 7'h02, 32'd5,          32'd7,         32'd0,         1'b1, 1});
      vecs.push_back('{2'b10, 3'b001, 7'h00, 32'd1,          32'h0000_0021, 32'd2,         1'b0, 1});
      vecs.push_back('{2'b10, 3'b011, 7'h00, 32'd1,          32'hFFFF_FFFF, 32'd1,         1'b0, 1});
      vecs.push_back('{2'b10, 3'b010, 7'h00, 32'd1,          32'hFFFF_FFFF, 32'd0,         1'b0, 1});
      vecs.push_back('{2'b10, 3'b000, 7'h20, 32'd3,          32'd5,         32'hFFFF_FFFE, 1'b0, 1});
      vecs.push_back('{2'b10, 3'b010, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33});
      vecs.push_back('{2'b10, 3'b000, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0, 33});
      vecs.push_back('{2'b10, 3'b011, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33});
      vecs.push_back('{2'b11, 3'b101, 7'h00, 32'h8000_0000, 32'h0000_0404, 32'h0800_0000, 1'b0, 1});
      vecs.push_back('{2'b11, 3'b101, 7'h7F, 32'h8000_0000, 32'h0000_0404, 32'hF800_0000, 1'b0, 1});
      vecs.push_back('{2'b11, 3'b101, 7'h5F, 32'h8000_0000, 32'h0000_0404, 32'h0800_0000, 1'b0, 1});
      vecs.push_back('{2'b11, 3'b011, 7'h55, 32'd5,          32'd7,         32'd1,         1'b0, 1});
      vecs.push_back('{2'b10, 3'b100, 7'h01, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 33});
      vecs.push_back('{2'b10, 3'b110, 7'h01, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 33});
      vecs.push_back('{2'b10, 3'b101, 7'h01, 32'd100,        32'd7,         32'd14,        1'b0, 33});
      vecs.push_back('{2'b10, 3'b111, 7'h01, 32'd100,        32'd7,         32'd2,         1'b0, 33});

      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
      nm_valid_i = 1'b0; nm_ready_i = 1'b1;
      ALUOp_i = '0; funct3_i = '0; funct7_i = '0; src1_i = '0; src2_i = '0;
      #2 rst_i = 1'b0;
      #1;
      check("reset_ready", 64'(ready_o), 64'd1);
      check("reset_valid", 64'(valid_o), 64'd0);
      check("reset_result", 64'(result_o), 64'd0);
      check("reset_illegal", 64'(illegal_o), 64'd0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b1;

      // Directed vectors
      foreach (vecs[i]) begin
         check($sformatf("vec%0d_ready", i), 64'(ready_o), 64'd1);
         run_op(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, res, ill, lat);
         check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].res));
         check($sformatf("vec%0d_illegal", i), 64'(ill), 64'(vecs[i].ill));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      end

      // Random operations against the reference model
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 7))
            0, 1, 2: op = 2'b10;
            3, 4, 5: op = 2'b11;
            6:       op = 2'b00;
            default: op = 2'b01;
         endcase
         case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = 7'($urandom);
         endcase
         funct3_i = 3'($urandom);
         src1_i   = pick();
         src2_i   = pick();
         e = model(op, funct3_i, f7, src1_i, src2_i, 1'b1);
         run_op(op, funct3_i, f7, src1_i, src2_i, res, ill, lat);
         check($sformatf("rnd%0d_result", i), 64'(res), 64'(e.res));
         check($sformatf("rnd%0d_illegal", i), 64'(ill), 64'(e.ill));
         check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(e.lat));
      end

      // DONE held while ready_i=0; valid_i pulses ignored; no accept on the consume edge
      ready_i = 1'b0;
      ALUOp_i = 2'b10; funct3_i = 3'b000; funct7_i = 7'h00; src1_i = 32'd100; src2_i = 32'd23;
      valid_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      valid_i = 1'b0;
      check("hold_first_valid", 64'(valid_o), 64'd1);
      held = result_o;
      check("hold_first_result", 64'(held), 64'd123);
      for (int k = 0; k < 5; k++) begin
         funct7_i = 7'h20; src1_i = 32'($urandom); src2_i = 32'($urandom);
         valid_i = 1'b1;
         @(posedge clk_i);
         @(negedge clk_i);
         check($sformatf("hold%0d_result", k), 64'(result_o), 64'd123);
         check($sformatf("hold%0d_ready", k), 64'(ready_o), 64'd0);
         check($sformatf("hold%0d_valid", k), 64'(valid_o), 64'd1);
      end
      ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      valid_i = 1'b0;
      check("consume_valid", 64'(valid_o), 64'd0);
      check("consume_ready", 64'(ready_o), 64'd1);
      @(negedge clk_i);
      check("consume_no_accept", 64'(valid_o), 64'd0);

      // Reset during BUSY discards a divu
      run_op(2'b10, 3'b000, 7'h00, 32'd1, 32'd1, res, ill, lat);
      check("pre_reset_result", 64'(result_o), 64'd2);
      ALUOp_i = 2'b10; funct3_i = 3'b101; funct7_i = 7'h01; src1_i = 32'd1000; src2_i = 32'd3;
      valid_i = 1'b1;
      @(posedge clk_i);
      repeat (10) @(negedge clk_i);
      valid_i = 1'b0;
      check("busy_ready", 64'(ready_o), 64'd0);
      #2 rst_i = 1'b0;
      #1;
      check("busy_rst_ready", 64'(ready_o), 64'd1);
      check("busy_rst_valid", 64'(valid_o), 64'd0);
      check("busy_rst_result", 64'(result_o), 64'd0);
      check("busy_rst_illegal", 64'(illegal_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk_i);
         if (valid_o) seen++;
      end
      check("busy_rst_no_valid", 64'(seen), 64'd0);

      // Reset during DONE clears a held illegal result
      ready_i = 1'b0;
      ALUOp_i = 2'b00;
      valid_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      valid_i = 1'b0;
      check("done_illegal_valid", 64'(valid_o), 64'd1);
      check("done_illegal_flag", 64'(illegal_o), 64'd1);
      #2 rst_i = 1'b0;
      #1;
      check("done_rst_valid", 64'(valid_o), 64'd0);
      check("done_rst_illegal", 64'(illegal_o), 64'd0);
      check("done_rst_ready", 64'(ready_o), 64'd1);
      @(negedge clk_i);
      rst_i = 1'b1;
      ready_i = 1'b1;
      @(negedge clk_i);
      check("done_rst_no_valid", 64'(valid_o), 64'd0);

      // First edge after reset release accepts a request
      rst_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      run_op(2'b10, 3'b000, 7'h00, 32'd2, 32'd3, res, ill, lat);
      check("post_reset_result", 64'(res), 64'd5);
      check("post_reset_latency", 64'(lat), 64'd1);

      // M_EN=0 instance: M ops are illegal in one cycle, base ops still work
      ALUOp_i = 2'b10; funct3_i = 3'b000; funct7_i = 7'h01; src1_i = 32'd3; src2_i = 32'd5;
      nm_valid_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      nm_valid_i = 1'b0;
      check("nm_mul_valid", 64'(nm_valid_o), 64'd1);
      check("nm_mul_illegal", 64'(nm_illegal_o), 64'd1);
      check("nm_mul_result", 64'(nm_result_o), 64'd0);
      @(negedge clk_i);
      check("nm_idle_ready", 64'(nm_ready_o), 64'd1);
      funct3_i = 3'b100;
      nm_valid_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      nm_valid_i = 1'b0;
      check("nm_div_illegal", 64'(nm_illegal_o), 64'd1);
      @(negedge clk_i);
      funct3_i = 3'b000; funct7_i = 7'h00;
      nm_valid_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      nm_valid_i = 1'b0;
      check("nm_add_valid", 64'(nm_valid_o), 64'd1);
      check("nm_add_illegal", 64'(nm_illegal_o), 64'd0);
      check("nm_add_result", 64'(nm_result_o), 64'd8);
      @(negedge clk_i);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
